// File: rtl/order_countdown.sv
// Per-order BCD countdown timer with serve/expiry scoring and a saturating miss counter.
// Define ORDER_BONUS_EN so that a serve earns 1 + the tens digit of the remaining time.
module order_countdown #(
  parameter logic [7:0]  DEFAULT_TIME = 8'h30,
  parameter int unsigned SCORE_W      = 8
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               tick_in,
  input  logic               start,
  input  logic               serve,
  input  logic               pause,
  input  logic [7:0]         load_bcd,
  output logic [7:0]         time_bcd,
  output logic [1:0]         state,
  output logic               running,
  output logic               expired,
  output logic               served,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         miss_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_RUN     = 2'b01,
    S_PAUSED  = 2'b10,
    S_EXPIRED = 2'b11
  } state_t;

  state_t             st;
  logic               tick_d;
  logic               tick_rise;
  logic [7:0]         load_value;
  logic [7:0]         time_dec;
  logic [SCORE_W-1:0] points;
  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W-1:0] score_next;

  assign state     = st;
  assign tick_rise = tick_in & ~tick_d;

  // A zero or any non-decimal digit falls back to the default start time.
  always_comb begin
    load_value = load_bcd;
    if (load_bcd[7:4] > 4'd9 || load_bcd[3:0] > 4'd9 || load_bcd == 8'h00)
      load_value = DEFAULT_TIME;
  end

  // Only reached while running, where the time is never 00.
  always_comb begin
    time_dec = time_bcd;
    if (time_bcd[3:0] == 4'd0) begin
      time_dec[7:4] = time_bcd[7:4] - 4'd1;
      time_dec[3:0] = 4'd9;
    end else begin
      time_dec[3:0] = time_bcd[3:0] - 4'd1;
    end
  end

  always_comb begin
`ifdef ORDER_BONUS_EN
    points = SCORE_W'(time_bcd[7:4]) + SCORE_W'(1);
`else
    points = SCORE_W'(1);
`endif
    score_sum  = {1'b0, score} + {1'b0, points};
    score_next = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      st       <= S_IDLE;
      time_bcd <= DEFAULT_TIME;
      score    <= '0;
      miss_cnt <= '0;
      running  <= 1'b0;
      expired  <= 1'b0;
      served   <= 1'b0;
      tick_d   <= 1'b0;
    end else begin
      tick_d  <= tick_in;
      expired <= 1'b0;
      served  <= 1'b0;
      unique case (st)
        S_IDLE: begin
          if (start) begin
            time_bcd <= load_value;
            st       <= S_RUN;
            running  <= 1'b1;
          end
        end
        S_RUN: begin
          if (serve) begin
            score   <= score_next;
            served  <= 1'b1;
            st      <= S_IDLE;
            running <= 1'b0;
          end else if (pause) begin
            st      <= S_PAUSED;
            running <= 1'b0;
          end else if (tick_rise) begin
            time_bcd <= time_dec;
            if (time_dec == 8'h00) begin
              st      <= S_EXPIRED;
              running <= 1'b0;
              expired <= 1'b1;
              if (miss_cnt != '1)
                miss_cnt <= miss_cnt + 4'd1;
            end
          end
        end
        S_PAUSED: begin
          if (!pause) begin
            st      <= S_RUN;
            running <= 1'b1;
          end
        end
        S_EXPIRED: begin
          if (start) begin
            time_bcd <= load_value;
            st       <= S_RUN;
            running  <= 1'b1;
          end
        end
        default: begin
          st      <= S_IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_order_countdown.sv
// Randomized + directed bench for order_countdown against an integer-arithmetic reference model.
module tb_order_countdown;

  logic       clk_in = 1'b0;
  logic       reset, tick_in, start, serve, pause;
  logic [7:0] load_bcd;
  logic [7:0] time_bcd;
  logic [1:0] state;
  logic       running, expired, served;
  logic [7:0] score;
  logic [3:0] miss_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model: time as a plain decimal integer, state as 0..3.
  int m_time  = 30;
  int m_state = 0;
  int m_score = 0;
  int m_miss  = 0;
  bit m_tick_prev = 0;
  bit m_exp = 0;
  bit m_srv = 0;

  order_countdown #(.DEFAULT_TIME(8'h30), .SCORE_W(8)) dut (
    .clk_in(clk_in), .reset(reset), .tick_in(tick_in), .start(start),
    .serve(serve), .pause(pause), .load_bcd(load_bcd), .time_bcd(time_bcd),
    .state(state), .running(running), .expired(expired), .served(served),
    .score(score), .miss_cnt(miss_cnt)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int t);
    logic [7:0] b;
    b[7:4] = 4'((t / 10) % 10);
    b[3:0] = 4'(t % 10);
    return b;
  endfunction

  function automatic int load_time(input logic [7:0] b);
    int tens, ones;
    tens = int'(b[7:4]);
    ones = int'(b[3:0]);
    if (tens > 9 || ones > 9 || (tens == 0 && ones == 0)) return 30;
    return tens * 10 + ones;
  endfunction

  function automatic int serve_points(input int t);
`ifdef ORDER_BONUS_EN
    return 1 + t / 10;
`else
    return 1;
`endif
  endfunction

  task automatic model_update();
    bit rise;
    rise  = tick_in && !m_tick_prev;
    m_exp = 0;
    m_srv = 0;
    if (reset) begin
      m_time = 30; m_state = 0; m_score = 0; m_miss = 0; m_tick_prev = 0;
      return;
    end
    m_tick_prev = tick_in;
    case (m_state)
      0, 3: if (start) begin m_time = load_time(load_bcd); m_state = 1; end
      1: begin
        if (serve) begin
          m_score = m_score + serve_points(m_time);
          if (m_score > 255) m_score = 255;
          m_srv = 1;
          m_state = 0;
        end else if (pause) begin
          m_state = 2;
        end else if (rise) begin
          m_time = m_time - 1;
          if (m_time == 0) begin
            m_state = 3;
            m_exp = 1;
            if (m_miss < 15) m_miss++;
          end
        end
      end
      2: if (!pause) m_state = 1;
      default: m_state = 0;
    endcase
  endtask

  task automatic compare_all();
    check_val("time_bcd", time_bcd, to_bcd(m_time));
    check_val("state", state, m_state);
    check_val("running", running, m_state == 1);
    check_val("expired", expired, m_exp);
    check_val("served", served, m_srv);
    check_val("score", score, m_score);
    check_val("miss_cnt", miss_cnt, m_miss);
    check_val("exp_srv_excl", expired & served, 0);
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      model_update();
      #1;
      compare_all();
    end
  endtask

  task automatic idle_inputs();
    reset = 0; tick_in = 0; start = 0; serve = 0; pause = 0;
  endtask

  task automatic start_order(input logic [7:0] b);
    load_bcd = b; start = 1; step(); start = 0;
  endtask

  task automatic tick_pulse();
    tick_in = 1; step(); tick_in = 0; step();
  endtask

  initial begin
    idle_inputs();
    load_bcd = 8'h00;
    reset = 1; step(2); reset = 0;
    check_val("rst_time", time_bcd, 8'h30);
    check_val("rst_state", state, 2'b00);

    // 1: expiry after three ticks
    start_order(8'h03);
    tick_in = 1; step(); check_val("t1_02", time_bcd, 8'h02); tick_in = 0; step();
    tick_in = 1; step(); check_val("t1_01", time_bcd, 8'h01); tick_in = 0; step();
    tick_in = 1; step();
    check_val("t1_00", time_bcd, 8'h00);
    check_val("t1_exp", expired, 1'b1);
    tick_in = 0; step();
    check_val("t1_exp_once", expired, 1'b0);
    check_val("t1_state", state, 2'b11);
    check_val("t1_miss", miss_cnt, 4'd1);

    // 2: borrow, then a held tick counts once
    start_order(8'h10);
    tick_pulse();
    check_val("t2_09", time_bcd, 8'h09);
    tick_in = 1; step(20); tick_in = 0; step();
    check_val("t2_hold", time_bcd, 8'h08);
    serve = 1; step(); serve = 0;

    // 3: serve after two ticks
    start_order(8'h25);
    tick_pulse(); tick_pulse();
    check_val("t3_23", time_bcd, 8'h23);
    serve = 1; step(); serve = 0;
    check_val("t3_served", served, 1'b1);
    check_val("t3_state", state, 2'b00);
    step();
    check_val("t3_served_once", served, 1'b0);

    // 4: serve wins over a simultaneous tick
    start_order(8'h15);
    tick_in = 1; serve = 1; step(); tick_in = 0; serve = 0;
    check_val("t4_time", time_bcd, 8'h15);
    check_val("t4_state", state, 2'b00);

    // 5: pause holds time across ticks
    start_order(8'h20);
    pause = 1;
    for (int i = 0; i < 5; i++) tick_pulse();
    check_val("t5_time", time_bcd, 8'h20);
    check_val("t5_state", state, 2'b10);
    pause = 0; tick_in = 1; step();
    check_val("t5_resume", state, 2'b01);
    check_val("t5_no_tick", time_bcd, 8'h20);
    tick_in = 0; step();
    tick_pulse();
    check_val("t5_19", time_bcd, 8'h19);

    // 6: invalid loads, score saturation, reset mid-run
    serve = 1; step(); serve = 0;
    start_order(8'h3A); check_val("t6_3A", time_bcd, 8'h30);
    serve = 1; step(); serve = 0;
    start_order(8'h00); check_val("t6_00", time_bcd, 8'h30);
    for (int i = 0; i < 260; i++) begin
      start_order(8'h99);
      serve = 1; step(); serve = 0;
    end
    check_val("t6_sat", score, 8'd255);
    start_order(8'h42);
    tick_pulse();
    reset = 1; step(); reset = 0;
    check_val("t6_rst_time", time_bcd, 8'h30);
    check_val("t6_rst_score", score, 8'd0);
    check_val("t6_rst_state", state, 2'b00);

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      reset   = ($urandom_range(0, 299) == 0);
      start   = ($urandom_range(0, 7) == 0);
      serve   = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 15) == 0) pause = ~pause;
      tick_in = $urandom_range(0, 1);
      if ($urandom_range(0, 4) == 0) load_bcd = 8'($urandom);
      else load_bcd = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
